mbs_fsk_sequencer: RTL
======================

Name: mbs_fsk_sequencer

Overview:
- Controller that sequences the maximal-binary-sequence FSK datapath: steps a configurable Fibonacci LFSR and times each FSK bit with a tone-period counter.
- Drives `ready`, `shift`, `lfsr`, `count` and the FSK output, which route to user GPIOs (mprj_io[8..23]) in the wrapped user project.
- Configured by static inputs from the Wishbone register block.
- Supports start/stop handshake and finite or continuous bursts.

Parameters:
- LFSR_W, 5: LFSR width.
- CNT_W, 7: half-period counter width.
- BURST_W, 8: burst-length counter width.

Ports:
- wb_clk_i  in  1  system clock; all state changes on the rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- start  in  1  begin a burst; sampled only in IDLE.
- stop  in  1  abort; sampled in every state.
- cfg_seed  in  LFSR_W  initial LFSR value.
- cfg_taps  in  LFSR_W  feedback tap mask.
- cfg_div0  in  CNT_W  half-period in clocks for bit 0.
- cfg_div1  in  CNT_W  half-period in clocks for bit 1.
- cfg_tones  in  4  tone periods per bit.
- cfg_burst  in  BURST_W  bits per burst; 0 = continuous.
- ready  out  1  high only in IDLE.
- shift  out  1  1-cycle pulse when the LFSR advances.
- lfsr  out  LFSR_W  current LFSR state; the transmitted bit is lfsr[0].
- count  out  CNT_W  half-period down-counter.
- fsk_out  out  1  FSK waveform.
- done  out  1  1-cycle pulse at burst completion.

Behaviour:
- Reset values: state IDLE, ready=1, shift=0, done=0, lfsr=0, count=0, fsk_out=0, bit counter=0, half-period counter=0.
- Config is latched on start acceptance; config changes mid-burst have no effect.
- Zero sanitising:
  - latched seed 0 → 1 (avoids LFSR lock-up);
  - latched div 0 → 1;
  - latched tones 0 → 1.
- IDLE:
  - start=1 and stop=0 → latch config, lfsr<=seed, bit counter<=0, go LOAD.
  - start and stop both high → stay IDLE.
- LOAD (1 cycle):
  - ready=0;
  - count<=(lfsr[0] ? div1 : div0);
  - half-period counter<=2*tones;
  - go TONE.
- TONE:
  - count decrements each cycle.
  - At count==1: fsk_out toggles, count reloads the selected div, half-period counter decrements.
  - When the half-period counter reaches 0, go SHIFT.
  - fsk_out therefore returns to its starting level at every bit boundary (phase-continuous).
- SHIFT (1 cycle):
  - shift=1;
  - lfsr<={lfsr[LFSR_W-2:0], ^(lfsr & taps)};
  - bit counter++;
  - if cfg_burst!=0 and the bit counter reaches cfg_burst → DONE, else → LOAD.
- DONE (1 cycle): done=1, go IDLE.
- Latency:
  - start sampled at cycle N → LOAD at N+1 (ready low at N+1), TONE at N+2.
  - Bit length = 2*tones*div + 2 clocks.
- Continuous mode (burst=0): bit counter wraps at 2^BURST_W; the block never reaches DONE.
- stop in any non-IDLE state: next cycle IDLE, fsk_out=0, count=0, no done pulse, no shift pulse; lfsr holds its last value.
- start while not in IDLE is ignored.
- wb_rst_i mid-burst: all outputs return to reset values on the next edge.

Optional Feature:
- Macro: MBS_FSK_WRAP_DET_EN.
- Defined:
  - adds output port `seq_wrap` (1 bit);
  - pulses in the SHIFT cycle whose next LFSR value equals the latched (sanitised) seed, i.e. sequence period complete;
  - reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic burst: seed=5'h01, taps=5'h14, div0=3, div1=5, tones=1, burst=4, start pulse.
  - shift pulses with lfsr 01→02→04→09→12;
  - bit lengths 12, 8, 8, 12 clocks;
  - done one cycle after the 4th SHIFT;
  - ready high again the following cycle.
- Continuous with MBS_FSK_WRAP_DET_EN: same config, burst=0.
  - seq_wrap pulses on every 31st shift pulse;
  - lfsr never equals 0;
  - done never asserts.
- Abort: stop asserted in TONE of bit 2.
  - next cycle ready=1, fsk_out=0, count=0;
  - no done pulse;
  - lfsr holds 02.
- Sanitising: seed=0, div0=div1=0, tones=0, burst=2.
  - lfsr loads 01;
  - fsk_out toggles every TONE cycle;
  - each bit is 4 clocks;
  - done after 2 bits.
- Handshake corners:
  - start during TONE → ignored, burst unaffected;
  - start and stop together in IDLE → ready stays 1, no LOAD.
- Reset mid-burst: wb_rst_i high for 1 cycle during TONE.
  - all outputs at reset values the next cycle;
  - a fresh start then behaves as in the basic-burst scenario.

Source files
------------

// File: rtl/mbs_fsk_sequencer.sv
// mbs_fsk_sequencer
//   Sequencer for the maximal-binary-sequence FSK datapath. It steps a
//   configurable Fibonacci LFSR and times each transmitted bit (lfsr[0])
//   with a half-period down-counter. Bit 0 uses cfg_div0 and bit 1 uses
//   cfg_div1 as the half-period, and each bit lasts cfg_tones tone periods.
//   Bursts are either finite (cfg_burst bits) or continuous (cfg_burst == 0).
//
// Ports
//   wb_clk_i   : clock; all state changes on the rising edge
//   wb_rst_i   : synchronous active-high reset
//   start      : begin a burst (accepted only in IDLE, ignored with stop)
//   stop       : abort; returns to IDLE from any state
//   cfg_seed   : initial LFSR value (0 is replaced by 1)
//   cfg_taps   : LFSR feedback tap mask
//   cfg_div0/1 : half-period in clocks for bit 0 / bit 1 (0 is replaced by 1)
//   cfg_tones  : tone periods per bit (0 is replaced by 1)
//   cfg_burst  : bits per burst, 0 = continuous
//   ready      : high only in IDLE
//   shift      : one-cycle pulse in the cycle the LFSR advances
//   lfsr       : current LFSR state
//   count      : half-period down-counter
//   fsk_out    : FSK waveform
//   done       : one-cycle pulse at burst completion
//   seq_wrap   : (only with MBS_FSK_WRAP_DET_EN) pulses in the shift cycle
//                whose next LFSR value equals the latched seed
//
// Optional feature macro: MBS_FSK_WRAP_DET_EN
module mbs_fsk_sequencer #(
  parameter int LFSR_W  = 5,
  parameter int CNT_W   = 7,
  parameter int BURST_W = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start,
  input  logic               stop,
  input  logic [LFSR_W-1:0]  cfg_seed,
  input  logic [LFSR_W-1:0]  cfg_taps,
  input  logic [CNT_W-1:0]   cfg_div0,
  input  logic [CNT_W-1:0]   cfg_div1,
  input  logic [3:0]         cfg_tones,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               ready,
  output logic               shift,
  output logic [LFSR_W-1:0]  lfsr,
  output logic [CNT_W-1:0]   count,
  output logic               fsk_out,
  output logic               done
`ifdef MBS_FSK_WRAP_DET_EN
  ,
  output logic               seq_wrap
`endif
);

  // 2*tones needs one bit more than tones
  localparam int HP_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TONE  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [LFSR_W-1:0]  seed_l;
  logic [LFSR_W-1:0]  taps_l;
  logic [CNT_W-1:0]   div0_l;
  logic [CNT_W-1:0]   div1_l;
  logic [3:0]         tones_l;
  logic [BURST_W-1:0] burst_l;
  logic [BURST_W-1:0] bit_cnt;
  logic [HP_W-1:0]    hp_cnt;

  logic [BURST_W-1:0] bit_nxt;
  logic [LFSR_W-1:0]  lfsr_nxt;
  logic [CNT_W-1:0]   sel_div;
  logic               accept;

  // Zero values would lock the LFSR or stall the counters.
  function automatic logic [LFSR_W-1:0] nz_seed(input logic [LFSR_W-1:0] v);
    return (v == '0) ? LFSR_W'(1) : v;
  endfunction

  function automatic logic [CNT_W-1:0] nz_div(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  function automatic logic [3:0] nz_tones(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

  assign accept   = start && !stop;
  assign bit_nxt  = bit_cnt + 1'b1;
  assign lfsr_nxt = {lfsr[LFSR_W-2:0], ^(lfsr & taps_l)};
  assign sel_div  = lfsr[0] ? div1_l : div0_l;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and decoded strobes; stop wins in every non-IDLE state and
  // suppresses the shift/done strobe of that cycle.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = stop ? IDLE : TONE;
      end
      TONE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (count == CNT_W'(1) && hp_cnt == HP_W'(1)) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (stop) begin
          state_nxt = IDLE;
        end else begin
          shift = 1'b1;
          if (burst_l != '0 && bit_nxt == burst_l) state_nxt = DONE;
          else                                      state_nxt = LOAD;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        done      = !stop;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MBS_FSK_WRAP_DET_EN
  assign seq_wrap = shift && (lfsr_nxt == seed_l);
`endif

  // Datapath: config latch, LFSR, bit and half-period timing
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      lfsr    <= '0;
      count   <= '0;
      fsk_out <= 1'b0;
      bit_cnt <= '0;
      hp_cnt  <= '0;
    end else if (state != IDLE && stop) begin
      count   <= '0;
      fsk_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            seed_l  <= nz_seed(cfg_seed);
            taps_l  <= cfg_taps;
            div0_l  <= nz_div(cfg_div0);
            div1_l  <= nz_div(cfg_div1);
            tones_l <= nz_tones(cfg_tones);
            burst_l <= cfg_burst;
            lfsr    <= nz_seed(cfg_seed);
            bit_cnt <= '0;
          end
        end
        LOAD: begin
          count  <= sel_div;
          hp_cnt <= {tones_l, 1'b0};
        end
        TONE: begin
          // Each half-period ends on count==1; an even number of toggles
          // per bit keeps the waveform phase-continuous across bits.
          if (count == CNT_W'(1)) begin
            fsk_out <= ~fsk_out;
            count   <= sel_div;
            hp_cnt  <= hp_cnt - 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        SHIFT: begin
          lfsr    <= lfsr_nxt;
          bit_cnt <= bit_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
